uart_xmtr_stim: RTL and testbench
=================================

Name: uart_xmtr_stim

Overview:
- Serial transmit stage that drives the DUT's RS232 receive pin in system simulation. It is the stdin counterpart of the UART receiver model that captures DUT output.
- Accepts bytes over a valid/ready interface into an internal FIFO.
- Serialises each byte as an asynchronous frame: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Clocked by the same serial baud-reference clock as the receiver model. Bit timing is an integer count of clock cycles.

Parameters:
- CLKS_PER_BIT, 3: clock cycles per serial bit. Legal range 2..255.
- DEPTH, 16: FIFO depth in bytes. Must be a power of 2, range 4..256.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clock  in  1  baud-reference clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; flushes FIFO and aborts any frame.
- wr_data  in  8  byte to transmit.
- wr_valid  in  1  wr_data valid.
- wr_ready  out  1  FIFO can accept a byte; equals !full.
- fifo_count  out  $clog2(DEPTH)+1  bytes held in the FIFO, excluding the byte being shifted.
- busy  out  1  high while a frame is on the line.
- tx_done  out  1  one-cycle pulse when a frame's last stop bit completes.
- uart_sout  out  1  serial line; idles high.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high, ports named clock and reset.
- Reset values: uart_sout=1, busy=0, tx_done=0, fifo_count=0, wr_ready=1. FIFO pointers are cleared.
- Reset asserted mid-frame: uart_sout goes high immediately, without waiting for a clock edge. The partial frame is lost; no tx_done is issued.
- Write accept:
  - A write is accepted on a rising edge where wr_valid && wr_ready.
  - fifo_count increments on that edge.
  - wr_ready is combinational from the registered count, so a full FIFO never accepts a write.
- Simultaneous accept and pop: fifo_count is unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP. Each state holds for CLKS_PER_BIT cycles, counted by bit_cnt_clk from 0 to CLKS_PER_BIT-1.
  - IDLE to START: when the FIFO is non-empty, pop the head into shift_reg and drive uart_sout=0. busy=1 from that cycle on.
  - START to DATA: shift out bits 0..7 LSB first; a 3-bit index counts 0..7.
  - DATA to PARITY: when PARITY != 0. Parity bit is ~^data for odd, ^data for even, computed at pop time.
  - DATA or PARITY to STOP: uart_sout=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On STOP completion: tx_done pulses for 1 cycle. If the FIFO is non-empty, go straight to START on that same edge (no idle gap); otherwise go to IDLE and drop busy.
- Latency: with the FIFO empty and the FSM in IDLE, the start bit appears at uart_sout on the 2nd rising edge after the accepting edge.
- Frame length: (10 + (PARITY!=0) + (STOP_BITS-1)) * CLKS_PER_BIT cycles.
- Writes are accepted during transmission; a FIFO fill does not disturb the current frame.
- uart_sout is driven from a flop; it is glitch-free.
- Illegal parameter values stop simulation with $fatal at elaboration.

Test Plan:
- CLKS_PER_BIT=4, PARITY=0: write 0x55 to an idle block → uart_sout low 2 cycles after accept, then bits 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, stop), each 4 cycles. tx_done pulses at cycle 40 of the frame; busy falls with it.
- Back-to-back: write 0x00, 0xFF, 0xA5 in consecutive cycles → three contiguous 40-cycle frames with no idle between them. fifo_count reads 2 after the first pop, then 1, then 0. tx_done pulses three times.
- Full FIFO: DEPTH=4, hold wr_valid for 6 cycles while a frame is active → exactly 4 bytes accepted. wr_ready=0 while fifo_count=4. wr_ready returns to 1 the cycle after the next pop.
- PARITY=2, STOP_BITS=2, data 0x07 → parity bit 1 follows bit 7. Stop high lasts 8 cycles. Frame is 48 cycles.
- PARITY=1, data 0x07 → parity bit 0.
- Reset mid-frame: assert reset during data bit 3 of 0x3C with 2 bytes queued → uart_sout=1 within the same timestep, fifo_count=0, no tx_done. After release, the line stays idle until a new write.

Source files
------------

// File: rtl/uart_xmtr_stim.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_xmtr_stim                                             |
// | Description : Serial transmit stimulus stage. Bytes written over a       |
// |               valid/ready interface are queued in a FIFO and sent on     |
// |               uart_sout as asynchronous frames: start bit, 8 data bits   |
// |               LSB first, optional parity bit, 1 or 2 stop bits.          |
// |                                                                          |
// | Ports       : clock       baud-reference clock, rising-edge logic        |
// |               reset       asynchronous active-high; flushes FIFO and     |
// |                           aborts any frame in progress                   |
// |               wr_data     byte to transmit                               |
// |               wr_valid    wr_data valid                                  |
// |               wr_ready    FIFO can accept a byte (not full)              |
// |               fifo_count  bytes queued, excluding the byte being shifted |
// |               busy        high while a frame is on the line              |
// |               tx_done     one-cycle pulse when the last stop bit ends    |
// |               uart_sout   serial line, idles high                        |
// |                                                                          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module uart_xmtr_stim #(
   parameter int CLKS_PER_BIT = 3,
   parameter int DEPTH        = 16,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [7:0]               wr_data,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     busy,
   output logic                     tx_done,
   output logic                     uart_sout
);

   localparam int         AW        = $clog2(DEPTH);
   localparam int         CW        = AW + 1;
   localparam logic [7:0] LAST_CLK  = 8'(CLKS_PER_BIT - 1);
   localparam logic       LAST_STOP = (STOP_BITS == 2);

   // ------------------------------------------------------------------
   // Parameter legality, rejected at elaboration
   // ------------------------------------------------------------------
   if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 255) begin : g_bad_clks_per_bit
      $fatal(1, "uart_xmtr_stim: CLKS_PER_BIT must be 2..255");
   end
   if (DEPTH < 4 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $fatal(1, "uart_xmtr_stim: DEPTH must be a power of 2 in 4..256");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $fatal(1, "uart_xmtr_stim: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $fatal(1, "uart_xmtr_stim: STOP_BITS must be 1 or 2");
   end

   // ------------------------------------------------------------------
   // FIFO
   // ------------------------------------------------------------------
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop;
   logic          fifo_empty;
   logic [7:0]    head;
   logic          head_par;

   // Ready comes straight from the registered count, so a full FIFO can
   // never take a write regardless of what the FSM does in the same cycle.
   assign wr_ready   = (fifo_count != CW'(DEPTH));
   assign push       = wr_valid && wr_ready;
   assign fifo_empty = (fifo_count == '0);
   assign head       = mem[rd_ptr];
   assign head_par   = (PARITY == 1) ? ~^head : ^head;

   // Storage needs no reset: the pointers alone define what is valid.
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers are AW bits wide, so they wrap modulo DEPTH naturally.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
   end

   // ------------------------------------------------------------------
   // Frame FSM
   // ------------------------------------------------------------------
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   state_t     state,       state_nxt;
   logic [7:0] bit_cnt_clk, bit_cnt_clk_nxt;
   logic [2:0] bit_idx,     bit_idx_nxt;
   logic       stop_idx,    stop_idx_nxt;
   logic [7:0] shift_reg,   shift_reg_nxt;
   logic       par_bit,     par_bit_nxt;
   logic       done_nxt;
   logic       line;
   logic       bit_end;

   assign bit_end = (bit_cnt_clk == LAST_CLK);

   always_comb begin
      state_nxt       = state;
      bit_cnt_clk_nxt = bit_cnt_clk;
      bit_idx_nxt     = bit_idx;
      stop_idx_nxt    = stop_idx;
      shift_reg_nxt   = shift_reg;
      par_bit_nxt     = par_bit;
      pop             = 1'b0;
      done_nxt        = 1'b0;
      line            = 1'b1;

      case (state)
         ST_IDLE: begin
            line = 1'b1;
            if (!fifo_empty) begin
               pop             = 1'b1;
               shift_reg_nxt   = head;
               par_bit_nxt     = head_par;
               bit_cnt_clk_nxt = '0;
               state_nxt       = ST_START;
            end
         end

         ST_START: begin
            line = 1'b0;
            if (bit_end) begin
               bit_cnt_clk_nxt = '0;
               bit_idx_nxt     = '0;
               state_nxt       = ST_DATA;
            end else begin
               bit_cnt_clk_nxt = bit_cnt_clk + 8'd1;
            end
         end

         ST_DATA: begin
            // The current data bit always sits in shift_reg[0].
            line = shift_reg[0];
            if (bit_end) begin
               bit_cnt_clk_nxt = '0;
               shift_reg_nxt   = {1'b0, shift_reg[7:1]};
               if (bit_idx == 3'd7) begin
                  stop_idx_nxt = 1'b0;
                  state_nxt    = (PARITY != 0) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_idx_nxt = bit_idx + 3'd1;
               end
            end else begin
               bit_cnt_clk_nxt = bit_cnt_clk + 8'd1;
            end
         end

         ST_PARITY: begin
            line = par_bit;
            if (bit_end) begin
               bit_cnt_clk_nxt = '0;
               stop_idx_nxt    = 1'b0;
               state_nxt       = ST_STOP;
            end else begin
               bit_cnt_clk_nxt = bit_cnt_clk + 8'd1;
            end
         end

         ST_STOP: begin
            line = 1'b1;
            if (bit_end) begin
               bit_cnt_clk_nxt = '0;
               if (stop_idx == LAST_STOP) begin
                  done_nxt = 1'b1;
                  // Chain straight into the next frame when data is waiting
                  // so back-to-back bytes leave no idle gap on the line.
                  if (!fifo_empty) begin
                     pop           = 1'b1;
                     shift_reg_nxt = head;
                     par_bit_nxt   = head_par;
                     state_nxt     = ST_START;
                  end else begin
                     state_nxt = ST_IDLE;
                  end
               end else begin
                  stop_idx_nxt = 1'b1;
               end
            end else begin
               bit_cnt_clk_nxt = bit_cnt_clk + 8'd1;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // uart_sout is the registered image of the current state's line value,
   // so the line lags the state by one clock and never glitches. Reset
   // forces the line high asynchronously, mid-bit if necessary.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         bit_cnt_clk <= '0;
         bit_idx     <= '0;
         stop_idx    <= 1'b0;
         shift_reg   <= '0;
         par_bit     <= 1'b0;
         tx_done     <= 1'b0;
         uart_sout   <= 1'b1;
      end else begin
         state       <= state_nxt;
         bit_cnt_clk <= bit_cnt_clk_nxt;
         bit_idx     <= bit_idx_nxt;
         stop_idx    <= stop_idx_nxt;
         shift_reg   <= shift_reg_nxt;
         par_bit     <= par_bit_nxt;
         tx_done     <= done_nxt;
         uart_sout   <= line;
      end
   end

   assign busy = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_xmtr_stim.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_xmtr_stim                                          |
// | Description : Self-checking bench for uart_xmtr_stim. Three instances    |
// |               cover no parity / even parity + 2 stop / odd parity. A     |
// |               vector table drives single frames; hand sequences cover    |
// |               back-to-back frames, FIFO full and reset mid-frame.        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_uart_xmtr_stim;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] wd  [3];
   logic       wv  [3];
   logic       rdy [3];
   logic       bsy [3];
   logic       dn  [3];
   logic       so  [3];
   logic [2:0] cnt0;
   logic [4:0] cnt1;
   logic [4:0] cnt2;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   // inst 0: no parity, 1 stop, DEPTH 4
   uart_xmtr_stim #(.CLKS_PER_BIT(4), .DEPTH(4), .PARITY(0), .STOP_BITS(1)) u_a (
      .clock(clock), .reset(reset), .wr_data(wd[0]), .wr_valid(wv[0]),
      .wr_ready(rdy[0]), .fifo_count(cnt0), .busy(bsy[0]), .tx_done(dn[0]),
      .uart_sout(so[0]));

   // inst 1: even parity, 2 stop
   uart_xmtr_stim #(.CLKS_PER_BIT(4), .DEPTH(16), .PARITY(2), .STOP_BITS(2)) u_c (
      .clock(clock), .reset(reset), .wr_data(wd[1]), .wr_valid(wv[1]),
      .wr_ready(rdy[1]), .fifo_count(cnt1), .busy(bsy[1]), .tx_done(dn[1]),
      .uart_sout(so[1]));

   // inst 2: odd parity, 1 stop
   uart_xmtr_stim #(.CLKS_PER_BIT(4), .DEPTH(16), .PARITY(1), .STOP_BITS(1)) u_d (
      .clock(clock), .reset(reset), .wr_data(wd[2]), .wr_valid(wv[2]),
      .wr_ready(rdy[2]), .fifo_count(cnt2), .busy(bsy[2]), .tx_done(dn[2]),
      .uart_sout(so[2]));

   typedef struct {
      int          inst;
      logic [7:0]  data;
      int          nbits;
      logic [11:0] bits;   // line bits, bit 0 first on the wire
   } vec_t;

   vec_t vecs [7];

   function automatic int get_cnt(input int i);
      case (i)
         0:       return int'(cnt0);
         1:       return int'(cnt1);
         default: return int'(cnt2);
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Write one byte to an idle instance and check every cycle of its frame.
   // N0 is the falling edge after the accepting rising edge.
   task automatic send_check(input int i, input logic [7:0] d,
                             input int nbits, input logic [11:0] bits);
      int          flen;
      int          k;
      int          exp_line;
      logic [11:0] b;
      b    = bits;
      flen = nbits * 4;
      @(negedge clock);
      wd[i] = d;
      wv[i] = 1'b1;
      @(negedge clock);
      wv[i] = 1'b0;
      for (int j = 1; j <= flen + 3; j++) begin
         @(negedge clock);
         k        = (j - 2) / 4;
         exp_line = (j >= 2 && k < nbits) ? int'(b[k]) : 1;
         chk("frame_sout", int'(so[i]), exp_line);
         chk("frame_tx_done", int'(dn[i]), int'(j == flen + 1));
         chk("frame_busy", int'(bsy[i]), int'(j <= flen));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          pulses;
      int          guard;
      int          k;
      int          exp_line;
      int          exp_cnt;
      logic [29:0] pat;

      vecs[0] = '{0, 8'h55, 10, 12'h2AA};
      vecs[1] = '{0, 8'h3C, 10, 12'h278};
      vecs[2] = '{0, 8'hFF, 10, 12'h3FE};
      vecs[3] = '{1, 8'h07, 12, 12'hE0E};
      vecs[4] = '{1, 8'h00, 12, 12'hC00};
      vecs[5] = '{2, 8'h07, 11, 12'h40E};
      vecs[6] = '{2, 8'h81, 11, 12'h702};

      for (int i = 0; i < 3; i++) begin
         wd[i] = 8'h00;
         wv[i] = 1'b0;
      end
      reset = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("rst_sout", int'(so[i]), 1);
         chk("rst_busy", int'(bsy[i]), 0);
         chk("rst_tx_done", int'(dn[i]), 0);
         chk("rst_count", get_cnt(i), 0);
         chk("rst_ready", int'(rdy[i]), 1);
      end
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      for (int i = 0; i < 3; i++) begin
         chk("idle_sout", int'(so[i]), 1);
         chk("idle_busy", int'(bsy[i]), 0);
      end

      // ---------------- single-frame vector table ----------------
      for (int v = 0; v < 7; v++) begin
         send_check(vecs[v].inst, vecs[v].data, vecs[v].nbits, vecs[v].bits);
      end

      // ---------------- back-to-back 0x00, 0xFF, 0xA5 ----------------
      pat    = {10'h34A, 10'h3FE, 10'h200};
      pulses = 0;
      @(negedge clock);
      wd[0] = 8'h00;
      wv[0] = 1'b1;
      @(negedge clock);
      wd[0] = 8'hFF;
      for (int j = 1; j <= 125; j++) begin
         @(negedge clock);
         k        = (j - 2) / 4;
         exp_line = (j >= 2 && k < 30) ? int'(pat[k]) : 1;
         chk("b2b_sout", int'(so[0]), exp_line);
         chk("b2b_tx_done", int'(dn[0]), int'(j == 41 || j == 81 || j == 121));
         chk("b2b_busy", int'(bsy[0]), int'(j <= 120));
         exp_cnt = (j == 1) ? 1 : (j <= 40) ? 2 : (j <= 80) ? 1 : 0;
         chk("b2b_count", get_cnt(0), exp_cnt);
         if (dn[0]) pulses++;
         if (j == 1) wd[0] = 8'hA5;
         if (j == 2) wv[0] = 1'b0;
      end
      chk("b2b_pulses", pulses, 3);

      // ---------------- FIFO full (DEPTH 4) ----------------
      @(negedge clock);
      wd[0] = 8'h11;
      wv[0] = 1'b1;
      @(negedge clock);
      wv[0] = 1'b0;
      @(negedge clock);
      wv[0] = 1'b1;
      for (int j = 0; j < 6; j++) begin
         wd[0] = 8'h20 + 8'(j);
         @(negedge clock);
         exp_cnt = (j < 4) ? j + 1 : 4;
         chk("full_count", get_cnt(0), exp_cnt);
         chk("full_ready", int'(rdy[0]), int'(exp_cnt < 4));
      end
      wv[0] = 1'b0;
      repeat (33) @(negedge clock);
      chk("full_count_n40", get_cnt(0), 4);
      chk("full_ready_n40", int'(rdy[0]), 0);
      @(negedge clock);
      chk("full_count_n41", get_cnt(0), 3);
      chk("full_ready_n41", int'(rdy[0]), 1);
      chk("full_done_n41", int'(dn[0]), 1);
      pulses = 1;
      guard  = 0;
      while (bsy[0] && guard < 300) begin
         @(negedge clock);
         guard++;
         if (dn[0]) pulses++;
      end
      chk("full_drain_timeout", int'(guard < 300), 1);
      chk("full_pulses", pulses, 5);
      chk("full_drain_count", get_cnt(0), 0);

      // ---------------- reset during data bit 3 of 0x3C ----------------
      @(negedge clock);
      wd[0] = 8'h3C;
      wv[0] = 1'b1;
      @(negedge clock);
      wd[0] = 8'hAA;
      @(negedge clock);
      wd[0] = 8'hBB;
      @(negedge clock);
      wv[0] = 1'b0;
      repeat (17) @(negedge clock);
      chk("rmid_pre_sout", int'(so[0]), 1);
      chk("rmid_pre_count", get_cnt(0), 2);
      chk("rmid_pre_busy", int'(bsy[0]), 1);
      #2;
      reset = 1'b1;
      #1;
      chk("rmid_sout", int'(so[0]), 1);
      chk("rmid_count", get_cnt(0), 0);
      chk("rmid_busy", int'(bsy[0]), 0);
      chk("rmid_tx_done", int'(dn[0]), 0);
      chk("rmid_ready", int'(rdy[0]), 1);
      @(negedge clock);
      reset = 1'b0;
      pulses = 0;
      for (int j = 0; j < 60; j++) begin
         @(negedge clock);
         chk("rmid_idle_sout", int'(so[0]), 1);
         chk("rmid_idle_busy", int'(bsy[0]), 0);
         if (dn[0]) pulses++;
      end
      chk("rmid_no_done", pulses, 0);

      // ---------------- reset during a start bit (line low) ----------------
      @(negedge clock);
      wd[0] = 8'h00;
      wv[0] = 1'b1;
      @(negedge clock);
      wv[0] = 1'b0;
      repeat (2) @(negedge clock);
      chk("rstart_pre_sout", int'(so[0]), 0);
      #2;
      reset = 1'b1;
      #1;
      chk("rstart_sout", int'(so[0]), 1);
      chk("rstart_busy", int'(bsy[0]), 0);
      @(negedge clock);
      reset = 1'b0;
      repeat (45) @(negedge clock);
      chk("rstart_idle_sout", int'(so[0]), 1);
      chk("rstart_idle_count", get_cnt(0), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
